spi_frame_rx: RTL and testbench

- SPI mode-0 slave front end: synchronises raw SCLK/COPI/nCS pins into the system clock domain and shifts in 16-bit frames.
- Decodes each frame into a register write (7-bit address, 8-bit data) and presents it over a valid/ready handshake.
- Sits between the ui_in pins (ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS) and the control register bank that drives the PWM peripheral.
- Write-only protocol; read frames are accepted on the wire and dropped.

---
 rtl/spi_frame_rx.sv | 142 ++++++++++++++
 tb/tb_spi_frame_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: synchronises SCLK/COPI/nCS into the clk domain,
// shifts in 16-bit frames and presents register writes on a one-deep valid/ready buffer.
module spi_frame_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  input  logic       wr_ready,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       addr_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_hist_q, copi_hist_q, ncs_hist_q;

  // Synchronisers come out of reset at idle pin levels so no phantom edges appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      copi_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the chain shifts one stage per clock.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_in};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      copi_hist_q <= copi_sync_q[SYNC_STAGES-1];
      ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, sclk_rise, ncs_fall, ncs_rise;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic        addr_err_q, addr_err_d;
  logic        overrun_q, overrun_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a value unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    wr_valid_d  = wr_valid_q & ~wr_ready;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    overrun_d   = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = CHECK;
        end else if (sclk_rise && !ncs_s) begin
          // COPI history flop has the same pipeline age as the SCLK history flop.
          shift_d = {shift_q[14:0], copi_hist_q};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (cnt_q != 5'd16) begin
          frame_err_d = 1'b1;
        end else if (shift_q[15]) begin
          if (shift_q[14:8] > MAX_ADDR) begin
            addr_err_d = 1'b1;
          end else if (wr_valid_q && !wr_ready) begin
            overrun_d = 1'b1;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = shift_q[14:8];
            wr_data_d  = shift_q[7:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: bit-bangs SPI frames on the raw pins and
// checks decoded writes, error pulses, overrun and latency against hand values.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs, wr_ready;
  logic       wr_valid, frame_err, addr_err, overrun;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  spi_frame_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_in   (sclk),
    .copi_in   (copi),
    .ncs_in    (ncs),
    .wr_ready  (wr_ready),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .addr_err  (addr_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observer: pre-edge values at each rising clock define transfers and pulses.
  int         n_xfer = 0, n_ferr = 0, n_aerr = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  always @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      n_xfer++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (frame_err) n_ferr++;
    if (addr_err)  n_aerr++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    wait_clk(4);
  endtask

  task automatic shift_bits(input logic [16:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    wait_clk(4);
    ncs = 1'b1;
  endtask

  task automatic send(input logic [16:0] v, input int n);
    start_frame();
    shift_bits(v, n);
    end_frame();
  endtask

  int   x0, f0, a0;
  logic bad;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; wr_ready = 1'b1;
    wait_clk(3);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_flags", {frame_err, addr_err, overrun}, 0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wait_clk(1);
      bad = bad | wr_valid | frame_err | addr_err | overrun | (|wr_addr) | (|wr_data);
    end
    check("idle_quiet", bad, 0);

    // Good write with latency measured from the nCS pin rising edge.
    x0 = n_xfer;
    send(17'h080F0, 16);
    repeat (3) @(posedge clk);
    #1 check("lat_not_yet", wr_valid, 0);
    @(posedge clk);
    #1 check("lat_valid", wr_valid, 1);
    check("w1_addr", wr_addr, 7'h00);
    check("w1_data", wr_data, 8'hF0);
    @(posedge clk);
    #1 check("w1_one_cycle", wr_valid, 0);
    wait_clk(8);
    check("w1_xfers", n_xfer - x0, 1);

    x0 = n_xfer;
    send(17'h08455, 16);
    wait_clk(12);
    check("w2_xfers", n_xfer - x0, 1);
    check("w2_addr", last_addr, 7'h04);
    check("w2_data", last_data, 8'h55);

    // Malformed lengths and a read frame.
    x0 = n_xfer; f0 = n_ferr; a0 = n_aerr;
    send(17'h04091, 15);
    wait_clk(12);
    check("len15_ferr", n_ferr - f0, 1);
    send(17'h10246, 17);
    wait_clk(12);
    check("len17_ferr", n_ferr - f0, 2);
    send(17'h001AA, 16);
    wait_clk(12);
    check("read_ferr", n_ferr - f0, 2);
    check("bad_len_xfers", n_xfer - x0, 0);
    check("bad_len_aerr", n_aerr - a0, 0);

    // Address beyond the implemented range.
    x0 = n_xfer; f0 = n_ferr; a0 = n_aerr;
    send(17'h08512, 16);
    wait_clk(12);
    check("addr5_aerr", n_aerr - a0, 1);
    check("addr5_ferr", n_ferr - f0, 0);
    check("addr5_xfers", n_xfer - x0, 0);
    check("addr5_valid", wr_valid, 0);

    // Back-pressure: second write is dropped and overrun sticks.
    wr_ready = 1'b0;
    x0 = n_xfer;
    send(17'h08111, 16);
    wait_clk(12);
    check("bp1_valid", wr_valid, 1);
    check("bp1_ovr", overrun, 0);
    send(17'h08222, 16);
    wait_clk(12);
    check("bp2_valid", wr_valid, 1);
    check("bp2_addr", wr_addr, 7'h01);
    check("bp2_data", wr_data, 8'h11);
    check("bp2_ovr", overrun, 1);
    wr_ready = 1'b1;
    wait_clk(4);
    check("bp_xfers", n_xfer - x0, 1);
    check("bp_xfer_addr", last_addr, 7'h01);
    check("bp_xfer_data", last_data, 8'h11);
    check("bp_valid_clr", wr_valid, 0);
    check("bp_ovr_sticky", overrun, 1);

    // Reset in the middle of a frame.
    x0 = n_xfer;
    start_frame();
    shift_bits(17'h00103, 9);
    rst_n = 1'b0;
    wait_clk(2);
    check("mid_rst_valid", wr_valid, 0);
    check("mid_rst_ovr", overrun, 0);
    ncs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(12);
    check("mid_rst_no_stale", n_xfer - x0, 0);
    send(17'h0833C, 16);
    wait_clk(12);
    check("post_rst_xfers", n_xfer - x0, 1);
    check("post_rst_addr", last_addr, 7'h03);
    check("post_rst_data", last_data, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
